// File: rtl/key_filter_if.sv
// Key detector <-> key filter signal bundle.
// The master side is the camera key detector / test driver and the slave side is the filter.
interface key_filter_if #(
  parameter int NUM_KEYS = 17
);
  logic                frame_done;
  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] key_held;
  logic [NUM_KEYS-1:0] key_num;
  logic                key_change;

  modport master (
    output frame_done, key_raw,
    input  key_held, key_num, key_change
  );

  modport slave (
    input  frame_done, key_raw,
    output key_held, key_num, key_change
  );
endinterface

// File: rtl/key_filter.sv
// Per-key press/release debouncer advanced once per video frame.
// The debounced bitmap is reduced to a registered one-hot lowest-index key.

// One key: two-state hysteresis with a run-length counter.
module key_filter_lane #(
  parameter int PRESS_FRAMES   = 3,
  parameter int RELEASE_FRAMES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic frame_done_i,
  input  logic raw_i,
  output logic on_o
);
  typedef enum logic {OFF = 1'b0, ON = 1'b1} key_state_e;

  localparam logic [2:0] PRESS_TH   = 3'(PRESS_FRAMES);
  localparam logic [2:0] RELEASE_TH = 3'(RELEASE_FRAMES);

  key_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] cnt_inc;

  // State and run counter registers; reset discards any partial run.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= OFF;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Count the run that opposes the current state; any break restarts it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + 3'd1;
    if (frame_done_i) begin
      unique case (state_q)
        OFF: begin
          if (raw_i) begin
            if (cnt_inc == PRESS_TH) begin
              state_d = ON;
              cnt_d   = 3'd0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = 3'd0;
          end
        end
        ON: begin
          if (!raw_i) begin
            if (cnt_inc == RELEASE_TH) begin
              state_d = OFF;
              cnt_d   = 3'd0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = 3'd0;
          end
        end
        default: begin
          state_d = OFF;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  assign on_o = (state_q == ON);
endmodule

module key_filter #(
  parameter int NUM_KEYS       = 17,
  parameter int PRESS_FRAMES   = 3,
  parameter int RELEASE_FRAMES = 4
) (
  input  logic    clock,
  input  logic    reset,
  key_filter_if.slave bus
);
  logic [NUM_KEYS-1:0] key_held;
  logic [NUM_KEYS-1:0] key_num_d, key_num_q;
  logic                key_change_d, key_change_q;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_lane
    key_filter_lane #(
      .PRESS_FRAMES  (PRESS_FRAMES),
      .RELEASE_FRAMES(RELEASE_FRAMES)
    ) u_lane (
      .clock       (clock),
      .reset       (reset),
      .frame_done_i(bus.frame_done),
      .raw_i       (bus.key_raw[i]),
      .on_o        (key_held[i])
    );
  end

  // Two's-complement trick isolates the lowest held key; zero stays zero.
  always_comb begin
    key_num_d    = key_held & (~key_held + {{(NUM_KEYS-1){1'b0}}, 1'b1});
    key_change_d = (key_num_d != key_num_q);
  end

  // key_num and its change pulse land on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      key_num_q    <= '0;
      key_change_q <= 1'b0;
    end else begin
      key_num_q    <= key_num_d;
      key_change_q <= key_change_d;
    end
  end

  assign bus.key_held   = key_held;
  assign bus.key_num    = key_num_q;
  assign bus.key_change = key_change_q;
endmodule

// File: tb/tb_key_filter.sv
// Bench for key_filter: directed scenarios plus randomized frames against a frame-level model.
module tb_key_filter;
  localparam int NK = 17;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  key_filter_if #(.NUM_KEYS(NK)) bus ();

  key_filter #(.NUM_KEYS(NK), .PRESS_FRAMES(3), .RELEASE_FRAMES(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model: per key "held" flag and length of the current opposing run.
  typedef struct packed {
    logic [NK-1:0]      on;
    logic [NK-1:0][7:0] run;
  } mstate_t;

  mstate_t       m;
  logic [NK-1:0] exp_num;
  logic          exp_chg;

  function automatic logic [NK-1:0] lowest(input logic [NK-1:0] v);
    logic [NK-1:0] r;
    r = '0;
    for (int i = NK - 1; i >= 0; i--)
      if (v[i]) begin
        r = '0;
        r[i] = 1'b1;
      end
    return r;
  endfunction

  function automatic mstate_t step(input mstate_t s, input logic fd, input logic [NK-1:0] raw);
    mstate_t n;
    int need;
    n = s;
    if (fd) begin
      for (int i = 0; i < NK; i++) begin
        need = s.on[i] ? 4 : 3;
        if (raw[i] != s.on[i]) begin
          if (int'(s.run[i]) + 1 >= need) begin
            n.on[i]  = raw[i];
            n.run[i] = 8'd0;
          end else begin
            n.run[i] = s.run[i] + 8'd1;
          end
        end else begin
          n.run[i] = 8'd0;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m       <= '0;
      exp_num <= '0;
      exp_chg <= 1'b0;
    end else begin
      exp_num <= lowest(m.on);
      exp_chg <= (lowest(m.on) != exp_num);
      m       <= step(m, bus.frame_done, bus.key_raw);
    end
  end

  task automatic chk(input string name, input logic [NK-1:0] got, input logic [NK-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle compare against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("model_held", bus.key_held, m.on);
      chk("model_num", bus.key_num, exp_num);
      chk("model_change", {16'd0, bus.key_change}, {16'd0, exp_chg});
    end
  end

  task automatic cyc(input logic fd, input logic [NK-1:0] raw, input logic rst);
    bus.frame_done = fd;
    bus.key_raw    = raw;
    reset          = rst;
    @(negedge clock);
  endtask

  task automatic strobe(input logic [NK-1:0] raw);
    cyc(1'b1, raw, 1'b0);
    cyc(1'b0, NK'($urandom), 1'b0);
  endtask

  initial begin
    logic [NK-1:0] tgt, raw;
    bus.frame_done = 1'b0;
    bus.key_raw    = '0;
    @(negedge clock);
    chk_en = 1'b1;

    // Reset holds everything at zero even with strobes and all keys touched.
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1, 17'h1FFFF, 1'b1);
      chk("rst_held", bus.key_held, '0);
      chk("rst_num", bus.key_num, '0);
      chk("rst_change", {16'd0, bus.key_change}, '0);
    end
    strobe(17'h1FFFF);
    strobe(17'h1FFFF);
    chk("rst_no_advance", bus.key_held, '0);
    strobe(17'h1FFFF);
    chk("all_press", bus.key_held, 17'h1FFFF);
    chk("all_press_num", bus.key_num, 17'h00001);
    for (int k = 0; k < 4; k++) strobe('0);
    chk("all_release", bus.key_held, '0);

    // Clean press and release of key 5 with exact cycle alignment.
    strobe(17'h00020);
    strobe(17'h00020);
    cyc(1'b1, 17'h00020, 1'b0);
    chk("k5_held_t1", bus.key_held, 17'h00020);
    chk("k5_num_t1", bus.key_num, '0);
    cyc(1'b0, '0, 1'b0);
    chk("k5_num_t2", bus.key_num, 17'h00020);
    chk("k5_chg_t2", {16'd0, bus.key_change}, 17'd1);
    cyc(1'b0, '0, 1'b0);
    chk("k5_chg_t3", {16'd0, bus.key_change}, '0);
    for (int k = 0; k < 3; k++) strobe('0);
    chk("k5_still_held", bus.key_held, 17'h00020);
    cyc(1'b1, '0, 1'b0);
    chk("k5_rel_held", bus.key_held, '0);
    chk("k5_rel_num_t1", bus.key_num, 17'h00020);
    cyc(1'b0, '0, 1'b0);
    chk("k5_rel_num_t2", bus.key_num, '0);
    chk("k5_rel_chg", {16'd0, bus.key_change}, 17'd1);

    // Glitch rejection on key 0.
    strobe(17'h1); strobe(17'h1); strobe(17'h0); strobe(17'h1); strobe(17'h1);
    chk("glitch_held0", bus.key_held & 17'h1, '0);
    strobe(17'h1);
    chk("glitch_press0", bus.key_held & 17'h1, 17'h1);

    // Release bounce on key 0.
    strobe(17'h0); strobe(17'h0); strobe(17'h0); strobe(17'h1);
    strobe(17'h0); strobe(17'h0); strobe(17'h0);
    chk("bounce_held0", bus.key_held & 17'h1, 17'h1);
    strobe(17'h0);
    chk("bounce_rel0", bus.key_held & 17'h1, '0);

    // Priority between keys 3 and 10.
    for (int k = 0; k < 3; k++) strobe(17'h00408);
    chk("prio_held", bus.key_held, 17'h00408);
    chk("prio_num", bus.key_num, 17'h00008);
    for (int k = 0; k < 3; k++) strobe(17'h00400);
    cyc(1'b1, 17'h00400, 1'b0);
    chk("prio_rel3_held", bus.key_held, 17'h00400);
    chk("prio_rel3_num_t1", bus.key_num, 17'h00008);
    cyc(1'b0, '0, 1'b0);
    chk("prio_rel3_num_t2", bus.key_num, 17'h00400);
    chk("prio_rel3_chg", {16'd0, bus.key_change}, 17'd1);
    cyc(1'b0, '0, 1'b0);
    chk("prio_rel3_chg_end", {16'd0, bus.key_change}, '0);
    for (int k = 0; k < 4; k++) strobe('0);
    chk("prio_rel10_num", bus.key_num, '0);

    // Off-strobe immunity: key 7 held, key 2 two frames into a press.
    for (int k = 0; k < 3; k++) strobe(17'h00080);
    strobe(17'h00084);
    strobe(17'h00084);
    chk("imm_pre_held", bus.key_held, 17'h00080);
    for (int k = 0; k < 1000; k++) cyc(1'b0, NK'($urandom), 1'b0);
    chk("imm_held", bus.key_held, 17'h00080);
    chk("imm_num", bus.key_num, 17'h00080);
    strobe(17'h00084);
    chk("imm_cnt_kept", bus.key_held, 17'h00084);
    chk("imm_num2", bus.key_num, 17'h00004);

    // Randomized frames: slowly changing touches with noise, gaps, bursts, resets.
    tgt = '0;
    for (int f = 0; f < 1500; f++) begin
      for (int i = 0; i < NK; i++)
        if ($urandom_range(0, 5) == 0) tgt[i] = ~tgt[i];
      raw = tgt;
      for (int i = 0; i < NK; i++)
        if ($urandom_range(0, 9) == 0) raw[i] = ~raw[i];
      if ($urandom_range(0, 99) == 0) cyc(1'b1, raw, 1'b1);
      else cyc(1'b1, raw, 1'b0);
      for (int g = $urandom_range(0, 3); g > 0; g--) cyc(1'b0, NK'($urandom), 1'b0);
    end
    cyc(1'b0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/key_filter.md
# key_filter

Debounces the per-frame raw key-touch bitmap from the camera key detector and produces the stable 17-bit `key_num` consumed by the sound-playback stage. Each key runs its own press/release hysteresis counter, advanced once per video frame. The filtered bitmap is reduced to a single one-hot active key (lowest index wins), so the tone path plays exactly one note. An all-zero `key_num` means silence.

## Interface
Parameters:
- `NUM_KEYS`, 17, number of piano keys; width of all key buses.
- `PRESS_FRAMES`, 3, consecutive touched frames required to turn a key on (range 1..7).
- `RELEASE_FRAMES`, 4, consecutive untouched frames required to turn a key off (range 1..7).

Ports:
- `clock`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `frame_done`  in  1  one-cycle strobe, once per video frame; `key_raw` is valid on this cycle.
- `key_raw`  in  NUM_KEYS  raw touch flags from the detector; bit i = key i touched this frame.
- `key_held`  out  NUM_KEYS  debounced per-key state.
- `key_num`  out  NUM_KEYS  one-hot lowest-index held key, or 0 when no key is held.
- `key_change`  out  1  one-cycle pulse whenever `key_num` changes value.

## Operation
- Per key i: state bit `on[i]` (drives `key_held[i]`) and a 3-bit counter `cnt[i]`.
- Between `frame_done` strobes, all per-key state holds. `key_raw` is ignored when `frame_done`=0.
- On a `frame_done` cycle, key i is in one of two states:
  - OFF (`on`=0):
    - `key_raw[i]`=1: `cnt`+1. When the incremented value equals PRESS_FRAMES, go to ON and set `cnt`=0.
    - `key_raw[i]`=0: `cnt`=0.
  - ON (`on`=1):
    - `key_raw[i]`=0: `cnt`+1. When the incremented value equals RELEASE_FRAMES, go to OFF and set `cnt`=0.
    - `key_raw[i]`=1: `cnt`=0.
- The counter never exceeds its threshold, so it cannot wrap. Any interruption of a run restarts counting from 0.
- Priority encode: `key_num_next` = `key_held` & (~`key_held` + 1), which isolates the lowest set bit. The result is 0 when `key_held`=0.
- `key_num` is a register loaded from `key_num_next` every cycle.
- `key_change` = 1 for exactly the cycle in which the registered `key_num` takes a new value.
- Keys are independent. Multiple keys may change state on the same frame.
- Removing a higher-index key never changes `key_num`. Releasing the current lowest key moves `key_num` to the next-lowest held key, with no intermediate 0 cycle.

## Timing
- Reset (synchronous, priority over `frame_done`):
  - All `on`=0 and all `cnt`=0.
  - `key_held`=0, `key_num`=0, `key_change`=0.
- `key_held` updates on the clock edge that samples `frame_done`=1 (latency 1 cycle from the strobe).
- `key_num` updates one cycle after `key_held`. `key_change` is asserted in that same cycle.
- Press latency: PRESS_FRAMES strobes.
  - If the strobe that completes the press is in cycle T, then `key_held` is set at T+1 and `key_num` at T+2.
- Release latency: RELEASE_FRAMES strobes, with the same cycle alignment as press.
- `frame_done` held high on consecutive cycles: each high cycle counts as one frame. Upstream must not do this; the behaviour is defined only for verification.
- Reset asserted mid-count discards all progress. The first strobe after reset starts from `cnt`=0.
- No handshake back to the detector. The block accepts every strobe.

## Test plan
- Reset check: hold `reset` for 2 cycles while `frame_done`=1 and `key_raw`=17'h1FFFF.
  - Required: `key_held`=0, `key_num`=0, `key_change`=0 throughout, and no state advance.
- Clean press and release of key 5 (bit 5): 3 strobes with bit 5 set.
  - After strobe 3: `key_held`=17'h00020 at +1 cycle, then `key_num`=17'h00020 with `key_change`=1 for one cycle at +2.
  - Then 4 strobes with `key_raw`=0. Required: `key_held`=0, then `key_num`=0 with one `key_change` pulse.
- Glitch rejection: key 0 pattern 1,1,0,1,1 over 5 strobes.
  - Required: `key_held[0]` stays 0.
  - A 6th strobe with key 0 set gives `key_held[0]`=1.
- Release bounce: key 0 held; pattern 0,0,0,1,0,0,0 over 7 strobes.
  - Required: `key_held[0]` stays 1 for all 7; an 8th strobe at 0 releases it.
- Priority: keys 3 and 10 both pressed for 3 strobes.
  - Required: `key_held`=17'h00408 and `key_num`=17'h00008.
  - Then release key 3 only: `key_num` goes directly to 17'h00400 with one `key_change` pulse and no 0 cycle.
  - Releasing key 10 last gives `key_num`=0.
- Off-strobe immunity: toggle `key_raw` randomly every cycle with `frame_done`=0 for 1000 cycles.
  - Required: all outputs and counters unchanged.
